// File: rtl/mac_result_drain_if.sv
// ---------------------------------------------------------------------------
// mac_result_drain_if
// Bundles every non-clock, non-reset signal of mac_result_drain.
//
// Handshake semantics (all valid/ready pairs in this bundle):
//   A transfer happens on a rising clk edge where both valid and ready are 1.
//   A producer holding valid=1 keeps its payload stable until the transfer.
//   Valid never waits on ready; ready may depend on valid.
//
// Signal groups
//   block2host_val/rdy          : readout start handshake with the MAC unit
//   start_reading_result_matrix : informational acknowledge from the MAC unit
//   ext_*_c                     : C-SRAM read port (data returns 1 cycle after re)
//   done_reading_result_matrix  : single-cycle readout-complete pulse
//   out_val/rdy/data/last       : output element stream
//   busy                        : drain is not idle
//   dbg_state                   : drain FSM state (IDLE=0 READ=1 FLUSH=2 DONE=3)
//
// Modports
//   master : the drain block
//   slave  : the environment (MAC unit, C-SRAM, downstream consumer)
// ---------------------------------------------------------------------------
interface mac_result_drain_if #(
  parameter int M  = 4,
  parameter int N  = 4,
  parameter int DW = 66
);
  localparam int RW = $clog2(M);
  localparam int CW = $clog2(N);

  logic          block2host_val;
  logic          block2host_rdy;
  logic          start_reading_result_matrix;
  logic [RW-1:0] ext_row_addr_c;
  logic [CW-1:0] ext_col_addr_c;
  logic          ext_matrix_c_re;
  logic [DW-1:0] ext_data_out_c;
  logic          done_reading_result_matrix;
  logic          out_val;
  logic          out_rdy;
  logic [DW-1:0] out_data;
  logic          out_last;
  logic          busy;
  logic [1:0]    dbg_state;

  modport master (
    input  block2host_val, start_reading_result_matrix, ext_data_out_c, out_rdy,
    output block2host_rdy, ext_row_addr_c, ext_col_addr_c, ext_matrix_c_re,
           done_reading_result_matrix, out_val, out_data, out_last, busy, dbg_state
  );

  modport slave (
    output block2host_val, start_reading_result_matrix, ext_data_out_c, out_rdy,
    input  block2host_rdy, ext_row_addr_c, ext_col_addr_c, ext_matrix_c_re,
           done_reading_result_matrix, out_val, out_data, out_last, busy, dbg_state
  );
endinterface

// File: rtl/mac_result_drain.sv
// ---------------------------------------------------------------------------
// mac_result_drain
// Drains the MAC result matrix C: after the start handshake it walks C in
// row-major order issuing C-SRAM reads, buffers returned words in a small
// credit-controlled FIFO, streams them out with a last flag and pulses
// done_reading_result_matrix once the last element has been accepted.
//
// Ports
//   clk      : clock
//   resetn   : asynchronous active-low reset
//   bus      : mac_result_drain_if.master (handshakes, SRAM port, out stream)
//   checksum : XOR of the elements popped in the current readout
//              (present only with MAC_RESULT_DRAIN_CHECKSUM_EN defined)
//
// Optional feature macro: MAC_RESULT_DRAIN_CHECKSUM_EN
// ---------------------------------------------------------------------------
module mac_result_drain #(
  parameter int M                        = 4,
  parameter int N                        = 4,
  parameter int K                        = 4,
  parameter int DATA_WIDTH_INIT_MATRIX   = 32,
  parameter int DATA_WIDTH_RESULT_MATRIX = DATA_WIDTH_INIT_MATRIX*2 + $clog2(K),
  parameter int FIFO_DEPTH               = 2
) (
  input  logic                                clk,
  input  logic                                resetn,
  mac_result_drain_if.master                  bus
`ifdef MAC_RESULT_DRAIN_CHECKSUM_EN
  ,
  output logic [DATA_WIDTH_RESULT_MATRIX-1:0] checksum
`endif
);
  localparam int DW  = DATA_WIDTH_RESULT_MATRIX;
  localparam int RW  = $clog2(M);
  localparam int CW  = $clog2(N);
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int AW1 = AW + 1;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_READ = 2'd1, S_FLUSH = 2'd2, S_DONE = 2'd3} state_e;

  state_e        state_q, state_d;
  logic [RW-1:0] row_q, row_d;
  logic [CW-1:0] col_q, col_d;
  logic          inflight_q, inflight_d;
  logic          inflight_last_q, inflight_last_d;
  logic [DW:0]   mem_q [FIFO_DEPTH];   // {last, data}
  logic [DW:0]   mem_d [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;

  logic          fifo_nonempty, push, pop, can_issue, at_last, start_readout;
  logic          re, done;
  logic [DW:0]   head;
  logic          unused_start_ack;

  assign unused_start_ack = bus.start_reading_result_matrix;

  assign head          = mem_q[rd_ptr_q];
  assign fifo_nonempty = (count_q != '0);
  assign pop           = fifo_nonempty && bus.out_rdy;
  assign push          = inflight_q;
  // Credit: words buffered plus the read in flight, minus the one leaving now.
  assign can_issue     = (int'(count_q) + int'(inflight_q) - int'(pop)) < FIFO_DEPTH;
  assign at_last       = (row_q == RW'(M-1)) && (col_q == CW'(N-1));
  assign start_readout = (state_q == S_IDLE) && bus.block2host_val && resetn;

  always_comb begin
    state_d         = state_q;
    row_d           = row_q;
    col_d           = col_q;
    inflight_d      = 1'b0;
    inflight_last_d = 1'b0;
    mem_d           = mem_q;
    wr_ptr_d        = wr_ptr_q;
    rd_ptr_d        = rd_ptr_q;
    count_d         = count_q;
    re              = 1'b0;
    done            = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start_readout) begin
          state_d = S_READ;
          row_d   = '0;
          col_d   = '0;
        end
      end
      S_READ: begin
        if (can_issue) begin
          re              = 1'b1;
          inflight_d      = 1'b1;
          inflight_last_d = at_last;
          if (at_last) begin
            // Counters park at 0 so the next readout also starts at (0,0).
            row_d   = '0;
            col_d   = '0;
            state_d = S_FLUSH;
          end else if (col_q == CW'(N-1)) begin
            col_d = '0;
            row_d = row_q + 1'b1;
          end else begin
            col_d = col_q + 1'b1;
          end
        end
      end
      S_FLUSH: begin
        if (pop && head[DW]) state_d = S_DONE;
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (push) begin
      mem_d[wr_ptr_q] = {inflight_last_q, bus.ext_data_out_c};
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop) rd_ptr_d = rd_ptr_q + 1'b1;

    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q         <= S_IDLE;
      row_q           <= '0;
      col_q           <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      wr_ptr_q        <= '0;
      rd_ptr_q        <= '0;
      count_q         <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q         <= state_d;
      row_q           <= row_d;
      col_q           <= col_d;
      inflight_q      <= inflight_d;
      inflight_last_q <= inflight_last_d;
      wr_ptr_q        <= wr_ptr_d;
      rd_ptr_q        <= rd_ptr_d;
      count_q         <= count_d;
      mem_q           <= mem_d;
    end
  end

  // The credit rule must make a push into a full FIFO impossible.
  assert property (@(posedge clk) disable iff (!resetn)
    !(push && !pop && (count_q == AW1'(FIFO_DEPTH))));

  // Ready is gated by resetn so it reads 0 while reset is held.
  assign bus.block2host_rdy             = (state_q == S_IDLE) && resetn;
  assign bus.ext_row_addr_c             = row_q;
  assign bus.ext_col_addr_c             = col_q;
  assign bus.ext_matrix_c_re            = re;
  assign bus.done_reading_result_matrix = done;
  assign bus.out_val                    = fifo_nonempty;
  // Head is masked when empty so the stream outputs read 0 after reset.
  assign bus.out_data                   = fifo_nonempty ? head[DW-1:0] : '0;
  assign bus.out_last                   = fifo_nonempty && head[DW];
  assign bus.busy                       = (state_q != S_IDLE);
  assign bus.dbg_state                  = state_q;

`ifdef MAC_RESULT_DRAIN_CHECKSUM_EN
  logic [DW-1:0] checksum_q, checksum_d;

  always_comb begin
    checksum_d = checksum_q;
    if (start_readout)  checksum_d = '0;
    else if (pop)       checksum_d = checksum_q ^ head[DW-1:0];
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) checksum_q <= '0;
    else         checksum_q <= checksum_d;
  end

  assign checksum = checksum_q;
`endif
endmodule

// File: tb/tb_mac_result_drain.sv
// ---------------------------------------------------------------------------
// tb_mac_result_drain
// Directed sequence of readouts against mac_result_drain (M=N=4, DW=66,
// FIFO_DEPTH=2). Expected elements come from a row-major walk of the bench's
// own copy of C held in exp_q; a monitor compares every accepted element.
// ---------------------------------------------------------------------------
module tb_mac_result_drain;
  localparam int M     = 4;
  localparam int N     = 4;
  localparam int DW    = 66;
  localparam int DEPTH = 2;

  // ---------------- clock / reset ----------------
  logic clk    = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  mac_result_drain_if #(.M(M), .N(N), .DW(DW)) bus ();

`ifdef MAC_RESULT_DRAIN_CHECKSUM_EN
  logic [DW-1:0] checksum;
`endif

  mac_result_drain #(
    .M(M), .N(N), .K(4), .DATA_WIDTH_INIT_MATRIX(32), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk),
    .resetn(resetn),
    .bus(bus)
`ifdef MAC_RESULT_DRAIN_CHECKSUM_EN
    ,
    .checksum(checksum)
`endif
  );

  // ---------------- bench state ----------------
  int            checks = 0;
  int            errors = 0;
  logic [DW:0]   exp_q[$];            // {last, data}
  logic [DW-1:0] c_mem [M][N];
  int            issued = 0, popped = 0, max_out = 0, done_cnt = 0, stable_err = 0;
  bit            stall_prev = 1'b0;
  logic [DW-1:0] prev_data;
  logic [DW:0]   mon_e;

  int            r_first_re, r_first_val, r_done, r_hs_bad;
  logic [1:0]    r_row, r_col;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- C-SRAM model ----------------
  always @(posedge clk) begin
    if (bus.ext_matrix_c_re)
      bus.ext_data_out_c <= c_mem[bus.ext_row_addr_c][bus.ext_col_addr_c];
    else
      bus.ext_data_out_c <= DW'({$urandom, $urandom, $urandom});
  end

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (!resetn) begin
      stall_prev = 1'b0;
    end else begin
      if (bus.ext_matrix_c_re) issued++;
      if (bus.out_val && bus.out_rdy) begin
        if (exp_q.size() == 0) begin
          check("unexpected_pop", 1, 0);
        end else begin
          mon_e = exp_q.pop_front();
          check("out_elem", {bus.out_last, bus.out_data}, mon_e);
        end
        popped++;
      end
      if (issued - popped > max_out) max_out = issued - popped;
      if (stall_prev && (!bus.out_val || bus.out_data !== prev_data)) stable_err++;
      stall_prev = bus.out_val && !bus.out_rdy;
      prev_data  = bus.out_data;
      if (bus.done_reading_result_matrix) done_cnt++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic fill_mem(input bit pattern);
    for (int r = 0; r < M; r++)
      for (int c = 0; c < N; c++)
        c_mem[r][c] = pattern ? DW'(16*r + c) : DW'({$urandom, $urandom, $urandom});
  endtask

  function automatic logic [DW-1:0] model_xor();
    logic [DW-1:0] x = '0;
    for (int r = 0; r < M; r++)
      for (int c = 0; c < N; c++) x ^= c_mem[r][c];
    return x;
  endfunction

  // mode: 0 out_rdy high, 1 stall 10 cycles after 1st element, 2 random out_rdy,
  //       3 random out_rdy with block2host_val toggling, 4 reset after 7 pops.
  // Entered and left at #1 after a rising edge.
  task automatic readout(input int mode);
    int base_pops, stall;
    for (int r = 0; r < M; r++)
      for (int c = 0; c < N; c++)
        exp_q.push_back({(r == M-1 && c == N-1), c_mem[r][c]});
    r_first_re = -1; r_first_val = -1; r_done = -1; r_hs_bad = 0;
    r_row = 'x; r_col = 'x;
    base_pops = popped; stall = 0; max_out = 0;
    bus.block2host_val = 1'b1;
    bus.out_rdy = (mode == 2 || mode == 3) ? 1'($urandom_range(0, 1)) : 1'b1;
    for (int cyc = 1; cyc <= 400; cyc++) begin
      @(posedge clk); #1;
      if (bus.ext_matrix_c_re && r_first_re < 0) begin
        r_first_re = cyc; r_row = bus.ext_row_addr_c; r_col = bus.ext_col_addr_c;
      end
      if (bus.out_val && r_first_val < 0) r_first_val = cyc;
      if (bus.block2host_rdy || !bus.busy) r_hs_bad++;
      if (bus.done_reading_result_matrix) begin
        r_done = cyc;
        bus.block2host_val = 1'b0;
        bus.out_rdy = 1'b0;
        break;
      end
      if (mode == 4 && popped - base_pops >= 7) begin
        resetn = 1'b0;
        bus.block2host_val = 1'b0;
        bus.out_rdy = 1'b0;
        return;
      end
      bus.start_reading_result_matrix = (cyc == 1);
      bus.block2host_val = (mode == 3) ? 1'($urandom_range(0, 1)) : 1'b0;
      case (mode)
        1: begin
          if (popped - base_pops >= 1 && stall < 10) begin
            bus.out_rdy = 1'b0; stall++;
          end else begin
            bus.out_rdy = 1'b1;
          end
        end
        2, 3:    bus.out_rdy = 1'($urandom_range(0, 1));
        default: bus.out_rdy = 1'b1;
      endcase
    end
  endtask

  task automatic after_readout(input int done_base);
    check("done_seen", (r_done > 0), 1);
    @(posedge clk); #1;
    check("rdy_after_done", bus.block2host_rdy, 1);
    check("done_single_cycle", bus.done_reading_result_matrix, 0);
    check("busy_after_done", bus.busy, 0);
    check("elements_left", exp_q.size(), 0);
    check("hs_during_run", r_hs_bad, 0);
    check("done_count", done_cnt - done_base, 1);
    check("first_addr", {r_row, r_col}, 4'h0);
    @(posedge clk); #1;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int done_base;
    bus.block2host_val = 1'b0;
    bus.start_reading_result_matrix = 1'b0;
    bus.out_rdy = 1'b0;
    fill_mem(1'b1);

    // reset state
    #3;
    check("rst_rdy", bus.block2host_rdy, 0);
    check("rst_out_val", bus.out_val, 0);
    check("rst_out_data", bus.out_data, 0);
    check("rst_out_last", bus.out_last, 0);
    check("rst_re", bus.ext_matrix_c_re, 0);
    check("rst_addr", {bus.ext_row_addr_c, bus.ext_col_addr_c}, 0);
    check("rst_done", bus.done_reading_result_matrix, 0);
    check("rst_busy", bus.busy, 0);
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
    @(posedge clk); #1;
    check("idle_rdy", bus.block2host_rdy, 1);
    check("idle_busy", bus.busy, 0);

    // basic drain, C[r][c] = 16r+c, out_rdy high
    done_base = done_cnt;
    readout(0);
    check("lat_first_re", r_first_re, 1);
    check("lat_first_val", r_first_val, 3);
    check("lat_done", r_done, 19);
`ifdef MAC_RESULT_DRAIN_CHECKSUM_EN
    check("checksum_pattern", checksum, model_xor());
`endif
    after_readout(done_base);

    // backpressure: stall 10 cycles from the 2nd element
    fill_mem(1'b0);
    done_base = done_cnt;
    stable_err = 0;
    readout(1);
    check("bp_max_outstanding", max_out, DEPTH);
    check("bp_stable_head", stable_err, 0);
    after_readout(done_base);

    // three consecutive random-ready readouts, last one toggling block2host_val
    for (int k = 0; k < 3; k++) begin
      fill_mem(1'b0);
      done_base = done_cnt;
      readout(k == 2 ? 3 : 2);
      check("rand_max_outstanding", (max_out <= DEPTH), 1);
`ifdef MAC_RESULT_DRAIN_CHECKSUM_EN
      check("checksum_rand", checksum, model_xor());
`endif
      after_readout(done_base);
    end
    check("rand_stable_head", stable_err, 0);

    // reset after 7 elements popped
    fill_mem(1'b0);
    done_base = done_cnt;
    readout(4);
    #1;
    check("mid_rst_out_val", bus.out_val, 0);
    check("mid_rst_out_data", bus.out_data, 0);
    check("mid_rst_out_last", bus.out_last, 0);
    check("mid_rst_re", bus.ext_matrix_c_re, 0);
    check("mid_rst_busy", bus.busy, 0);
    check("mid_rst_rdy", bus.block2host_rdy, 0);
    check("mid_rst_addr", {bus.ext_row_addr_c, bus.ext_col_addr_c}, 0);
    repeat (3) @(posedge clk);
    #1 resetn = 1'b1;
    exp_q.delete();
    @(posedge clk); #1;
    check("mid_rst_no_done", done_cnt - done_base, 0);
    check("mid_rst_rdy_back", bus.block2host_rdy, 1);

    // readout after the reset restarts at (0,0)
    fill_mem(1'b0);
    done_base = done_cnt;
    readout(0);
    check("restart_first_re", r_first_re, 1);
    check("restart_done", r_done, 19);
    after_readout(done_base);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach the end of the sequence");
    $fatal(1, "watchdog expired");
  end
endmodule
